alu_exec_ctrl: RTL and testbench

Instruction decode and four-phase execute sequencer that drives the 8-bit ALU datapath of the Mini-CPU. It accepts 14-bit PIC16-style instruction words from fetch and reads the file-register operand. It generates every ALU control and operand input, captures the ALU result and C/DC/Z flags, and writes back to W or the file register. The ALU stays a separate combinational block wired to this controller's ports.

---
 rtl/mini_cpu_pkg.sv | 89 ++++++++
 rtl/alu_exec_ctrl_decode.sv | 114 +++++++++++
 rtl/alu_exec_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg
// Shared definitions for the Mini-CPU execute controller. This package holds
// the opcode constants (instr[13:8]), the ALU select encodings, the sequencer
// state enum and the per-instruction control bundle.
//
// External ALU contract, expressed through the select encodings:
//   out_mux  : 00 through, 01 shift, 10 logic, 11 adder
//   through  : op_mux_l 00 passes op_A1, 01 passes op_A; clr forces 0,
//              swap_n_mov swaps nibbles
//   shift    : rlf_n_rrf=1 rotates op_A1 left through C_in, 0 rotates right
//   logic    : op_mux_l selects AND/IOR/XOR of op_A,op_B, or ~op_A
//   adder    : op_A plus (op_B | 1 | 0xFF by op_mux_a); sub=1 gives op_A-op_B
package mini_cpu_pkg;

  // Byte-oriented file-register opcodes
  localparam logic [5:0] OPC_MOVWF = 6'b000000;
  localparam logic [5:0] OPC_CLR   = 6'b000001;
  localparam logic [5:0] OPC_SUBWF = 6'b000010;
  localparam logic [5:0] OPC_DECF  = 6'b000011;
  localparam logic [5:0] OPC_IORWF = 6'b000100;
  localparam logic [5:0] OPC_ANDWF = 6'b000101;
  localparam logic [5:0] OPC_XORWF = 6'b000110;
  localparam logic [5:0] OPC_ADDWF = 6'b000111;
  localparam logic [5:0] OPC_MOVF  = 6'b001000;
  localparam logic [5:0] OPC_COMF  = 6'b001001;
  localparam logic [5:0] OPC_INCF  = 6'b001010;
  localparam logic [5:0] OPC_RRF   = 6'b001100;
  localparam logic [5:0] OPC_RLF   = 6'b001101;
  localparam logic [5:0] OPC_SWAPF = 6'b001110;

  // Literal opcodes; '?' bits are don't-care within the family
  localparam logic [5:0] OPC_MOVLW = 6'b1100??;
  localparam logic [5:0] OPC_IORLW = 6'b111000;
  localparam logic [5:0] OPC_ANDLW = 6'b111001;
  localparam logic [5:0] OPC_XORLW = 6'b111010;
  localparam logic [5:0] OPC_SUBLW = 6'b11110?;
  localparam logic [5:0] OPC_ADDLW = 6'b11111?;

  // ALU output mux
  localparam logic [1:0] OUT_THRU  = 2'b00;
  localparam logic [1:0] OUT_SHIFT = 2'b01;
  localparam logic [1:0] OUT_LOGIC = 2'b10;
  localparam logic [1:0] OUT_ADD   = 2'b11;

  // op_mux_l in logic mode
  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_IOR = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;
  localparam logic [1:0] LOGIC_COM = 2'b11;

  // op_mux_l in through mode
  localparam logic [1:0] THRU_A1 = 2'b00;
  localparam logic [1:0] THRU_A  = 2'b01;

  // op_mux_a: second adder operand
  localparam logic [1:0] ADD_W    = 2'b00;
  localparam logic [1:0] ADD_ONE  = 2'b01;
  localparam logic [1:0] ADD_ONES = 2'b10;

  // Flag masks, ordered {Z, DC, C} like STATUS
  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_C    = 3'b001;
  localparam logic [2:0] FLAG_Z    = 3'b100;
  localparam logic [2:0] FLAG_CDZ  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_Q1,
    ST_Q2,
    ST_Q3,
    ST_Q4
  } state_t;

  typedef struct packed {
    logic [1:0] out_mux;
    logic [1:0] op_mux_l;
    logic [1:0] op_mux_a;
    logic       clr;
    logic       swap_n_mov;
    logic       rlf_n_rrf;
    logic       sub;
    logic       lit_op;
    logic       a1_w;
    logic       dest_w;
    logic       wr_file;
    logic [2:0] flag_mask;
  } ctrl_t;

endpackage

// File: rtl/alu_exec_ctrl_decode.sv
// alu_decode
// Purely combinational decode of an instruction's opcode and destination bit
// into the control bundle that drives the external ALU and the writeback.
// Unsupported encodings (NOP, bit-oriented, control flow) produce an
// all-zero bundle, so they write nothing and touch no flags.
//
// Ports:
//   opcode  in  6  instr[13:8]
//   d       in  1  instr[7], destination select for byte ops (1 = file)
//   ctrl    out    decoded control bundle
module alu_decode
  import mini_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       d,
  output ctrl_t      ctrl
);

  logic byte_op;

  // Opcode decode. Byte ops only pick ALU settings here; their destination
  // is applied once after the case from the d bit.
  always_comb begin
    ctrl    = '0;
    byte_op = 1'b0;
    casez (opcode)
      OPC_ADDWF, OPC_SUBWF: begin
        ctrl.out_mux   = OUT_ADD;
        ctrl.op_mux_a  = ADD_W;
        ctrl.sub       = (opcode == OPC_SUBWF);
        ctrl.flag_mask = FLAG_CDZ;
        byte_op        = 1'b1;
      end
      OPC_INCF, OPC_DECF: begin
        ctrl.out_mux   = OUT_ADD;
        ctrl.op_mux_a  = (opcode == OPC_INCF) ? ADD_ONE : ADD_ONES;
        ctrl.flag_mask = FLAG_Z;
        byte_op        = 1'b1;
      end
      OPC_ANDWF, OPC_IORWF, OPC_XORWF, OPC_COMF: begin
        ctrl.out_mux   = OUT_LOGIC;
        ctrl.op_mux_l  = (opcode == OPC_ANDWF) ? LOGIC_AND :
                         (opcode == OPC_IORWF) ? LOGIC_IOR :
                         (opcode == OPC_XORWF) ? LOGIC_XOR : LOGIC_COM;
        ctrl.flag_mask = FLAG_Z;
        byte_op        = 1'b1;
      end
      OPC_CLR: begin
        ctrl.out_mux   = OUT_THRU;
        ctrl.clr       = 1'b1;
        ctrl.a1_w      = ~d;
        ctrl.flag_mask = FLAG_Z;
        byte_op        = 1'b1;
      end
      OPC_MOVF: begin
        ctrl.out_mux   = OUT_THRU;
        ctrl.flag_mask = FLAG_Z;
        byte_op        = 1'b1;
      end
      OPC_SWAPF: begin
        ctrl.out_mux    = OUT_THRU;
        ctrl.swap_n_mov = 1'b1;
        ctrl.flag_mask  = FLAG_NONE;
        byte_op         = 1'b1;
      end
      OPC_RLF, OPC_RRF: begin
        ctrl.out_mux   = OUT_SHIFT;
        ctrl.rlf_n_rrf = (opcode == OPC_RLF);
        ctrl.flag_mask = FLAG_C;
        byte_op        = 1'b1;
      end
      OPC_MOVWF: begin
        // d=0 in this row is NOP and friends, left as an empty bundle
        if (d) begin
          ctrl.out_mux  = OUT_THRU;
          ctrl.op_mux_l = THRU_A1;
          ctrl.a1_w     = 1'b1;
          byte_op       = 1'b1;
        end
      end
      OPC_ADDLW, OPC_SUBLW: begin
        ctrl.out_mux   = OUT_ADD;
        ctrl.op_mux_a  = ADD_W;
        ctrl.sub       = (opcode[1] == 1'b0);
        ctrl.lit_op    = 1'b1;
        ctrl.dest_w    = 1'b1;
        ctrl.flag_mask = FLAG_CDZ;
      end
      OPC_ANDLW, OPC_IORLW, OPC_XORLW: begin
        ctrl.out_mux   = OUT_LOGIC;
        ctrl.op_mux_l  = (opcode == OPC_ANDLW) ? LOGIC_AND :
                         (opcode == OPC_IORLW) ? LOGIC_IOR : LOGIC_XOR;
        ctrl.lit_op    = 1'b1;
        ctrl.dest_w    = 1'b1;
        ctrl.flag_mask = FLAG_Z;
      end
      OPC_MOVLW: begin
        // Through path must pass the literal (op_A), not the file operand
        ctrl.out_mux   = OUT_THRU;
        ctrl.op_mux_l  = THRU_A;
        ctrl.lit_op    = 1'b1;
        ctrl.dest_w    = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
    if (byte_op) begin
      ctrl.dest_w  = ~d;
      ctrl.wr_file = d;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Four-phase decode/execute sequencer for the Mini-CPU 8-bit ALU datapath.
// An instruction is accepted in IDLE or Q4, decoded in Q1 while the file
// register is addressed, its operand is registered in Q2, the external ALU
// result and flags are captured at the end of Q3 and written back in Q4.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready  fetch handshake, 14-bit instruction
//   file_rd_addr/file_rd_data  file-register read (data one cycle later)
//   file_wr_en/addr/data       file-register write, pulsed in Q4
//   clr, swap_n_mov, rlf_n_rrf, sub, op_mux_l, op_mux_a, out_mux,
//   C_in, op_A1, op_A, op_B    ALU controls and operands
//   alu_out, c_new, dc_new, z_new  ALU results
//   w_reg                      working register
//   status                     {Z, DC, C}
module alu_exec_ctrl
  import mini_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [13:0] instr,
  output logic        instr_ready,
  output logic [6:0]  file_rd_addr,
  input  logic [7:0]  file_rd_data,
  output logic        file_wr_en,
  output logic [6:0]  file_wr_addr,
  output logic [7:0]  file_wr_data,
  output logic        clr,
  output logic        swap_n_mov,
  output logic        rlf_n_rrf,
  output logic        sub,
  output logic [1:0]  op_mux_l,
  output logic [1:0]  op_mux_a,
  output logic [1:0]  out_mux,
  output logic        C_in,
  output logic [7:0]  op_A1,
  output logic [7:0]  op_A,
  output logic [7:0]  op_B,
  input  logic [7:0]  alu_out,
  input  logic        c_new,
  input  logic        dc_new,
  input  logic        z_new,
  output logic [7:0]  w_reg,
  output logic [2:0]  status
);

  state_t      state;
  state_t      state_next;
  logic [13:0] instr_reg;
  ctrl_t       ctrl_dec;
  ctrl_t       ctrl_reg;
  logic [7:0]  operand_reg;
  logic [7:0]  result_reg;
  logic [2:0]  flags_reg;
  logic        accept;

  alu_decode u_decode (
    .opcode (instr_reg[13:8]),
    .d      (instr_reg[7]),
    .ctrl   (ctrl_dec)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake. Q4 doubles as an accept slot so a held
  // instr_valid sustains one instruction every four cycles.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = ST_Q1;
      end
      ST_Q1: state_next = ST_Q2;
      ST_Q2: state_next = ST_Q3;
      ST_Q3: state_next = ST_Q4;
      ST_Q4: begin
        instr_ready = 1'b1;
        state_next  = instr_valid ? ST_Q1 : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = instr_ready & instr_valid;

  // Per-phase datapath registers. W and STATUS update on the Q4 edge, so
  // an instruction accepted in Q4 already sees them when its Q3 arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg   <= '0;
      ctrl_reg    <= '0;
      operand_reg <= '0;
      result_reg  <= '0;
      flags_reg   <= '0;
      w_reg       <= '0;
      status      <= '0;
    end else begin
      if (accept) instr_reg <= instr;
      if (state == ST_Q1) ctrl_reg <= ctrl_dec;
      if (state == ST_Q2) operand_reg <= file_rd_data;
      if (state == ST_Q3) begin
        result_reg <= alu_out;
        flags_reg  <= {z_new, dc_new, c_new};
      end
      if (state == ST_Q4) begin
        if (ctrl_reg.dest_w) w_reg <= result_reg;
        status <= (status & ~ctrl_reg.flag_mask) |
                  (flags_reg & ctrl_reg.flag_mask);
      end
    end
  end

  assign file_rd_addr = instr_reg[6:0];
  assign file_wr_en   = (state == ST_Q4) && ctrl_reg.wr_file;
  assign file_wr_addr = instr_reg[6:0];
  assign file_wr_data = result_reg;

  assign clr        = ctrl_reg.clr;
  assign swap_n_mov = ctrl_reg.swap_n_mov;
  assign rlf_n_rrf  = ctrl_reg.rlf_n_rrf;
  assign sub        = ctrl_reg.sub;
  assign op_mux_l   = ctrl_reg.op_mux_l;
  assign op_mux_a   = ctrl_reg.op_mux_a;
  assign out_mux    = ctrl_reg.out_mux;
  assign C_in       = status[0];

  assign op_B  = w_reg;
  assign op_A  = ctrl_reg.lit_op ? instr_reg[7:0] : operand_reg;
  assign op_A1 = ctrl_reg.a1_w ? w_reg : operand_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl
// Bench for alu_exec_ctrl: a file-register memory, the external ALU and an
// instruction-level reference model. Issued instructions push their expected
// writeback into a scoreboard queue; a monitor pops it at each Q4.
module tb_alu_exec_ctrl;
  import mini_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic [13:0] instr;
  logic        instr_ready;
  logic [6:0]  file_rd_addr;
  logic [7:0]  file_rd_data;
  logic        file_wr_en;
  logic [6:0]  file_wr_addr;
  logic [7:0]  file_wr_data;
  logic        clr, swap_n_mov, rlf_n_rrf, sub;
  logic [1:0]  op_mux_l, op_mux_a, out_mux;
  logic        C_in;
  logic [7:0]  op_A1, op_A, op_B;
  logic [7:0]  alu_out;
  logic        c_new, dc_new, z_new;
  logic [7:0]  w_reg;
  logic [2:0]  status;

  typedef struct {
    logic       wr_en;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] w;
    logic [2:0] st;
    int         acc_cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       pend;
  bit         pending_w = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];
  logic [7:0] ref_w = 8'h00;
  logic [2:0] ref_st = 3'b000;
  logic [7:0] thru_src, b_eff;
  logic [8:0] sum;
  logic [4:0] nib;

  logic [5:0] opc_tab [23] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0C,
                               6'h0D, 6'h0E, 6'h30, 6'h33, 6'h38, 6'h39,
                               6'h3A, 6'h3C, 6'h3D, 6'h3E, 6'h3F};

  alu_exec_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .file_rd_addr (file_rd_addr),
    .file_rd_data (file_rd_data),
    .file_wr_en   (file_wr_en),
    .file_wr_addr (file_wr_addr),
    .file_wr_data (file_wr_data),
    .clr          (clr),
    .swap_n_mov   (swap_n_mov),
    .rlf_n_rrf    (rlf_n_rrf),
    .sub          (sub),
    .op_mux_l     (op_mux_l),
    .op_mux_a     (op_mux_a),
    .out_mux      (out_mux),
    .C_in         (C_in),
    .op_A1        (op_A1),
    .op_A         (op_A),
    .op_B         (op_B),
    .alu_out      (alu_out),
    .c_new        (c_new),
    .dc_new       (dc_new),
    .z_new        (z_new),
    .w_reg        (w_reg),
    .status       (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int a);
    case (a)
      16:      return 8'h01;
      32:      return 8'h80;
      33:      return 8'hA5;
      default: return 8'(a * 37 + 11);
    endcase
  endfunction

  // File-register memory: synchronous read, write on file_wr_en
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = init_val(i);
    file_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      file_rd_data <= mem[file_rd_addr];
      if (file_wr_en) mem[file_wr_addr] = file_wr_data;
    end
  end

  // External combinational ALU driven by the controller's selects
  always_comb begin
    alu_out  = 8'h00;
    c_new    = 1'b0;
    dc_new   = 1'b0;
    thru_src = 8'h00;
    b_eff    = 8'h00;
    sum      = 9'h000;
    nib      = 5'h00;
    case (out_mux)
      OUT_THRU: begin
        thru_src = (op_mux_l == THRU_A) ? op_A : op_A1;
        if (clr) alu_out = 8'h00;
        else if (swap_n_mov) alu_out = {thru_src[3:0], thru_src[7:4]};
        else alu_out = thru_src;
      end
      OUT_SHIFT: begin
        alu_out = rlf_n_rrf ? {op_A1[6:0], C_in} : {C_in, op_A1[7:1]};
        c_new   = rlf_n_rrf ? op_A1[7] : op_A1[0];
      end
      OUT_LOGIC: begin
        case (op_mux_l)
          LOGIC_AND: alu_out = op_A & op_B;
          LOGIC_IOR: alu_out = op_A | op_B;
          LOGIC_XOR: alu_out = op_A ^ op_B;
          default:   alu_out = ~op_A;
        endcase
      end
      default: begin
        b_eff = (op_mux_a == ADD_ONE) ? 8'h01 :
                (op_mux_a == ADD_ONES) ? 8'hFF : op_B;
        if (sub) b_eff = ~b_eff;
        sum     = {1'b0, op_A} + {1'b0, b_eff} + {8'h00, sub};
        nib     = {1'b0, op_A[3:0]} + {1'b0, b_eff[3:0]} + {4'h0, sub};
        alu_out = sum[7:0];
        c_new   = sum[8];
        dc_new  = nib[4];
      end
    endcase
  end

  assign z_new = (alu_out == 8'h00);

  // Instruction-level reference: what one instruction does to W, STATUS
  // and the file, from the instruction set's arithmetic rules.
  function automatic exp_t model(input logic [13:0] ins, input logic [7:0] w,
                                 input logic [7:0] f, input logic [2:0] st);
    exp_t       e;
    int         opc, fi, wi, ki, s;
    logic [7:0] res;
    logic       c, dc, to_w, to_f, bop;
    logic [2:0] mask;
    opc = int'(ins[13:8]);
    fi = int'(f); wi = int'(w); ki = int'(ins[7:0]);
    res = 8'h00; c = 1'b0; dc = 1'b0; mask = 3'b000;
    to_w = 1'b0; to_f = 1'b0; bop = 1'b1;
    case (opc)
      7:  begin s = fi + wi; res = 8'(s); c = s > 255;
                dc = (fi % 16 + wi % 16) > 15; mask = 3'b111; end
      2:  begin res = 8'(fi - wi); c = fi >= wi;
                dc = (fi % 16) >= (wi % 16); mask = 3'b111; end
      10: begin res = 8'(fi + 1); mask = 3'b100; end
      3:  begin res = 8'(fi - 1); mask = 3'b100; end
      5:  begin res = f & w; mask = 3'b100; end
      4:  begin res = f | w; mask = 3'b100; end
      6:  begin res = f ^ w; mask = 3'b100; end
      9:  begin res = 8'(255 - fi); mask = 3'b100; end
      1:  begin res = 8'h00; mask = 3'b100; end
      8:  begin res = f; mask = 3'b100; end
      14: begin res = 8'((fi % 16) * 16 + fi / 16); end
      13: begin res = 8'(fi * 2 + int'(st[0])); c = fi >= 128; mask = 3'b001; end
      12: begin res = 8'(fi / 2 + 128 * int'(st[0])); c = (fi % 2) == 1;
                mask = 3'b001; end
      0:  begin res = w; bop = ins[7]; end
      default: begin
        bop = 1'b0;
        if (opc >= 62) begin
          s = ki + wi; res = 8'(s); c = s > 255;
          dc = (ki % 16 + wi % 16) > 15; mask = 3'b111; to_w = 1'b1;
        end else if (opc == 60 || opc == 61) begin
          res = 8'(ki - wi); c = ki >= wi;
          dc = (ki % 16) >= (wi % 16); mask = 3'b111; to_w = 1'b1;
        end else if (opc == 57) begin
          res = ins[7:0] & w; mask = 3'b100; to_w = 1'b1;
        end else if (opc == 56) begin
          res = ins[7:0] | w; mask = 3'b100; to_w = 1'b1;
        end else if (opc == 58) begin
          res = ins[7:0] ^ w; mask = 3'b100; to_w = 1'b1;
        end else if (opc >= 48 && opc <= 51) begin
          res = ins[7:0]; to_w = 1'b1;
        end
      end
    endcase
    if (bop) begin
      to_f = ins[7];
      to_w = ~ins[7];
    end
    e.wr_en   = to_f;
    e.addr    = ins[6:0];
    e.data    = res;
    e.w       = to_w ? res : w;
    e.st      = (st & ~mask) | ({res == 8'h00, dc, c} & mask);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual,
               expected, $time);
    end
  endtask

  // Issue one instruction and wait (bounded) for acceptance. With track=1
  // the reference model is advanced and the expected writeback queued.
  task automatic applyStimulus(input logic [13:0] ins, input bit track);
    int   waited;
    exp_t e;
    instr       = ins;
    instr_valid = 1'b1;
    waited      = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!instr_ready && waited < 20);
    if (!instr_ready) begin
      checkOutput("accept_timeout", 16'(instr_ready), 16'h1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (track) begin
      e = model(ins, ref_w, ref_mem[ins[6:0]], ref_st);
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      if (e.wr_en) ref_mem[e.addr] = e.data;
      ref_w  = e.w;
      ref_st = e.st;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] rand_instr();
    int          idx;
    logic [5:0]  opc;
    logic [6:0]  addr;
    logic [13:0] ins;
    idx  = $urandom_range(0, 25);
    opc  = (idx < 23) ? opc_tab[idx] : 6'($urandom);
    addr = ($urandom_range(0, 4) == 0) ? 7'h03 : 7'($urandom_range(0, 15));
    ins  = {opc, 1'($urandom), addr};
    if (opc[5:4] == 2'b11) ins[7:0] = 8'($urandom);
    return ins;
  endfunction

  // Monitor: a rising instr_ready marks Q4. The file write is checked in
  // Q4, W and STATUS one cycle later, after the writeback edge.
  initial begin
    logic prev_ready;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1'b1;
        pending_w  = 1'b0;
        continue;
      end
      if (pending_w) begin
        checkOutput("w_reg", 16'(w_reg), 16'(pend.w));
        checkOutput("status", 16'(status), 16'(pend.st));
        pending_w = 1'b0;
      end
      if (instr_ready && !prev_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_wb", 16'(sb_q.size()), 16'h1);
        end else begin
          pend = sb_q.pop_front();
          checkOutput("latency", 16'(cyc - pend.acc_cyc), 16'd3);
          checkOutput("file_wr_en", 16'(file_wr_en), 16'(pend.wr_en));
          if (pend.wr_en) begin
            checkOutput("file_wr_addr", 16'(file_wr_addr), 16'(pend.addr));
            checkOutput("file_wr_data", 16'(file_wr_data), 16'(pend.data));
          end
          pending_w = 1'b1;
        end
      end else begin
        checkOutput("wr_en_outside_q4", 16'(file_wr_en), 16'h0);
      end
      prev_ready = instr_ready;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited, bad;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    instr_valid = 1'b0;
    instr       = 14'h0000;
    idleCycles(3);
    checkOutput("rst_w_reg", 16'(w_reg), 16'h0);
    checkOutput("rst_status", 16'(status), 16'h0);
    checkOutput("rst_instr_ready", 16'(instr_ready), 16'h1);
    checkOutput("rst_file_wr_en", 16'(file_wr_en), 16'h0);
    checkOutput("rst_out_mux", 16'(out_mux), 16'h0);
    checkOutput("rst_ops", 16'({op_A, op_A1}), 16'h0);
    checkOutput("rst_op_B", 16'(op_B), 16'h0);
    checkOutput("rst_ctl", 16'({clr, swap_n_mov, rlf_n_rrf, sub, op_mux_l, op_mux_a, C_in}), 16'h0);
    rst_n = 1'b1;
    idleCycles(2);

    applyStimulus(14'h300F, 1'b1);
    applyStimulus(14'h0790, 1'b1);
    applyStimulus(14'h3001, 1'b1);
    applyStimulus(14'h3EFF, 1'b1);
    applyStimulus(14'h3E00, 1'b1);
    applyStimulus(14'h0D20, 1'b1);
    applyStimulus(14'h0EA1, 1'b1);
    applyStimulus(14'h303C, 1'b1);
    applyStimulus(14'h1000, 1'b1);
    idleCycles(7);
    checkOutput("dir_w_final", 16'(w_reg), 16'h003C);
    checkOutput("dir_status_final", 16'(status), 16'h0005);
    checkOutput("dir_addwf_mem", 16'(mem[16]), 16'h0010);
    checkOutput("dir_swapf_mem", 16'(mem[33]), 16'h005A);

    applyStimulus(14'h0790, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_wr_en", 16'(file_wr_en), 16'h0);
    checkOutput("abort_w_reg", 16'(w_reg), 16'h0);
    checkOutput("abort_status", 16'(status), 16'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ref_w  = 8'h00;
    ref_st = 3'b000;
    @(negedge clk);
    checkOutput("abort_ready", 16'(instr_ready), 16'h1);
    checkOutput("abort_mem", 16'(mem[16]), 16'(ref_mem[16]));
    idleCycles(2);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(rand_instr(), 1'b1);
      if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 4));
    end

    waited = 0;
    while ((sb_q.size() != 0 || pending_w) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    idleCycles(2);
    checkOutput("drain", 16'(sb_q.size()), 16'h0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput("mem_final", 16'(bad), 16'h0);
    checkOutput("w_final", 16'(w_reg), 16'(ref_w));
    checkOutput("status_final", 16'(status), 16'(ref_st));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
